ncc_select: RTL and testbench
=============================

NCC_SELECT -- requirements
Module: ncc_select

Interface
REQ-001 SHALL use one clock, and its reset SHALL be asynchronous and active-low; ports: clk (clock) and rst_n (reset).
REQ-002 SHALL have the following ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  upstream results-stable level; low while the upstream is calculating.
- fsum  in  11  unsigned sum of the 16x16 reference window pixels.
- f2sum  in  14  unsigned sum of squared reference pixels.
- gsum  in  704  16 lanes x 44 bits, unsigned; lane k = bits [44k+43:44k].
- g2sum  in  896  16 lanes x 56 bits, unsigned; lane k = bits [56k+55:56k].
- fg  in  896  16 lanes x 56 bits, unsigned cross sums; same lane packing as g2sum.
- best_idx  out  4  lane index of the minimum cost.
- best_cost  out  96  minimum cost, unsigned.
- out_valid  out  1  one-cycle pulse when best_idx and best_cost update.
- busy  out  1  high in LOAD and SCAN.
- overrun  out  1  sticky; a new trigger arrived while busy.

Function
REQ-003 SHALL register valid into valid_d every cycle; trigger = valid & ~valid_d.
- A constant-high valid SHALL NOT trigger, including the high level present at reset release.
REQ-004 SHALL implement the FSM IDLE -> LOAD -> SCAN -> DONE -> IDLE.
REQ-005 IDLE: on trigger, SHALL capture fsum, f2sum, gsum, g2sum and fg into internal registers, then go to LOAD.
REQ-006 LOAD: SHALL clear lane counter k to 0, set best_tmp to all-ones and best_k to 0, then go to SCAN.
REQ-007 SCAN: SHALL evaluate exactly one lane per cycle, for k = 0..15 (16 cycles).
- Lane k SHALL replace the running best only if cost_k < best_tmp (strict less-than); on ties the lowest index wins.
- After k = 15, SHALL go to DONE.
REQ-008 DONE: SHALL load best_idx and best_cost from the running best, pulse out_valid for one cycle, and return to IDLE.
REQ-009 Latency: trigger sampled at posedge T produces out_valid high during the cycle following posedge T+18.
- LOAD at T+1, SCAN at T+2..T+17, DONE at T+18.
- Back-to-back triggers are accepted from the cycle after DONE.
REQ-010 Plain cost (macro absent): cost_k = f2sum + g2sum_k - 2*fg_k.
- Computed in 58-bit signed arithmetic.
- A negative result SHALL clamp to 0.
- The result SHALL be zero-extended to 96 bits.
REQ-011 All arithmetic SHALL use the captured registers only; input changes after capture SHALL NOT affect the result.
REQ-012 A trigger while busy or in DONE SHALL be ignored and SHALL set overrun; the scan in progress SHALL complete unaffected.
REQ-013 best_idx and best_cost SHALL hold their values between out_valid pulses.
REQ-014 busy SHALL be high in LOAD and SCAN, and low in IDLE and DONE.

Reset
REQ-015 On rst_n low, the block SHALL asynchronously enter IDLE and force to 0: valid_d, best_idx, best_cost, out_valid, busy, overrun, k and all capture registers.
REQ-016 Reset mid-SCAN SHALL abort the scan with no out_valid pulse.
REQ-017 After reset release, the first trigger SHALL require a 0->1 transition of valid.

Configuration
REQ-018 Macro NCC_ZSSD_EN SHALL select the cost function.
- When defined: zero-mean cost cost_k = 256*(f2sum + g2sum_k - 2*fg_k) - (fsum - gsum_k)^2.
  - Computed in 96-bit signed arithmetic.
  - The difference term SHALL be 45-bit signed.
  - A negative result SHALL clamp to 0.
- When undefined: REQ-010 applies, and no squarer or 96-bit subtractor SHALL be synthesized.
- Ports and timing SHALL be identical in both builds.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset release with valid=1 held constant -> no out_valid for 100 cycles; outputs all 0.
- Plain build; valid 0->1; f2sum=100; lane 5: g2sum=100, fg=100; all other lanes: g2sum=300, fg=10 -> out_valid 19 cycles after trigger, best_idx=5, best_cost=0.
- Ties: all lanes have g2sum=50, fg=20, f2sum=10 -> best_idx=0, best_cost=20.
- Clamp: lane 3 has fg=1000, g2sum=0, f2sum=0 -> lane 3 cost 0; best_idx=3.
- Trigger pulse during SCAN -> overrun=1; result equals the first-capture expectation; only one out_valid.
- NCC_ZSSD_EN build; fsum=256; lane 7: gsum=256, g2sum=f2sum=fg=256 -> lane 7 cost 0; best_idx=7. rst_n pulsed mid-SCAN in a second run -> no out_valid.

Source files
------------

// File: rtl/ncc_select.sv
// ncc_select: picks the best of 16 candidate windows from precomputed sums.
//
// A rising edge on valid captures the reference sums (fsum, f2sum) and the
// 16 per-lane candidate sums (gsum, g2sum, fg). The block then scans one
// lane per cycle and reports the lane with the smallest cost. On equal
// costs the lowest lane index wins.
//
// Optional feature macro: NCC_ZSSD_EN
//   undefined : cost_k = f2sum + g2sum_k - 2*fg_k            (58-bit signed)
//   defined   : cost_k = 256*(f2sum + g2sum_k - 2*fg_k)
//                        - (fsum - gsum_k)^2                  (96-bit signed)
//   In both cases a negative cost clamps to 0.
//
// Ports:
//   clk       in   1    system clock, rising edge
//   rst_n     in   1    asynchronous active-low reset
//   valid     in   1    upstream results-stable level; rising edge triggers
//   fsum      in   11   sum of reference pixels
//   f2sum     in   14   sum of squared reference pixels
//   gsum      in   704  16 x 44-bit lane sums, lane k = [44k+43:44k]
//   g2sum     in   896  16 x 56-bit lane squared sums, lane k = [56k+55:56k]
//   fg        in   896  16 x 56-bit lane cross sums, same packing as g2sum
//   best_idx  out  4    lane index of minimum cost
//   best_cost out  96   minimum cost
//   out_valid out  1    one-cycle pulse when best_idx/best_cost update
//   busy      out  1    high in LOAD and SCAN
//   overrun   out  1    sticky; trigger arrived while not idle
//
// Handshake: there is no backpressure. A trigger is a 0->1 transition of
// valid seen while IDLE; triggers in any other state are dropped and flagged
// on overrun. Results are qualified by the single-cycle out_valid pulse and
// hold until the next pulse.
module ncc_select (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic [10:0]  fsum,
    input  logic [13:0]  f2sum,
    input  logic [703:0] gsum,
    input  logic [895:0] g2sum,
    input  logic [895:0] fg,
    output logic [3:0]   best_idx,
    output logic [95:0]  best_cost,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;

    logic          valid_d;
    // Set once valid has been seen low after reset, so a level that is
    // already high at reset release cannot look like a rising edge.
    logic          armed;
    logic          trigger;

    logic [10:0]   fsum_q;
    logic [13:0]   f2sum_q;
    logic [703:0]  gsum_q;
    logic [895:0]  g2sum_q;
    logic [895:0]  fg_q;

    logic [3:0]    k;
    logic [95:0]   best_tmp;
    logic [3:0]    best_k;

    logic [55:0]   g2_lane;
    logic [55:0]   fg_lane;
    logic [43:0]   gs_lane;
    logic signed [57:0] plain;
    logic [95:0]   cost;

    assign trigger = valid & ~valid_d & armed;
    assign busy    = (state == LOAD) || (state == SCAN);

    // Lane k selection from the captured registers.
    always_comb begin
        g2_lane = '0;
        fg_lane = '0;
        gs_lane = '0;
        for (int i = 0; i < 16; i++) begin
            if (k == 4'(i)) begin
                g2_lane = g2sum_q[56*i +: 56];
                fg_lane = fg_q[56*i +: 56];
                gs_lane = gsum_q[44*i +: 44];
            end
        end
    end

    assign plain = $signed({44'd0, f2sum_q}) + $signed({2'b00, g2_lane})
                 - $signed({1'b0, fg_lane, 1'b0});

`ifdef NCC_ZSSD_EN
    logic signed [44:0] diff;
    logic signed [95:0] diff_w;
    logic signed [95:0] scaled;
    logic signed [95:0] zcost;

    assign diff   = $signed({34'd0, fsum_q}) - $signed({1'b0, gs_lane});
    assign diff_w = 96'(diff);
    assign scaled = {{30{plain[57]}}, plain, 8'd0};
    assign zcost  = scaled - diff_w * diff_w;
    assign cost   = zcost[95] ? 96'd0 : zcost;
`else
    // fsum/gsum only feed the zero-mean cost; captured but unused here.
    logic unused_zssd;
    assign unused_zssd = ^{fsum_q, gsum_q, gs_lane};
    assign cost        = plain[57] ? 96'd0 : {38'd0, plain};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = LOAD;
            LOAD:    state_nxt = SCAN;
            SCAN:    if (k == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d   <= 1'b0;
            armed     <= 1'b0;
            fsum_q    <= '0;
            f2sum_q   <= '0;
            gsum_q    <= '0;
            g2sum_q   <= '0;
            fg_q      <= '0;
            k         <= '0;
            best_tmp  <= '0;
            best_k    <= '0;
            best_idx  <= '0;
            best_cost <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid_d   <= valid;
            out_valid <= 1'b0;
            if (!valid) armed <= 1'b1;
            if (trigger && state != IDLE) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        fsum_q  <= fsum;
                        f2sum_q <= f2sum;
                        gsum_q  <= gsum;
                        g2sum_q <= g2sum;
                        fg_q    <= fg;
                    end
                end
                LOAD: begin
                    k        <= '0;
                    best_tmp <= '1;
                    best_k   <= '0;
                end
                SCAN: begin
                    // Strict less-than keeps the earlier lane on ties.
                    if (cost < best_tmp) begin
                        best_tmp <= cost;
                        best_k   <= k;
                    end
                    k <= k + 4'd1;
                end
                DONE: begin
                    best_idx  <= best_k;
                    best_cost <= best_tmp;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ncc_select.sv
module tb_ncc_select;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic [10:0]  fsum;
    logic [13:0]  f2sum;
    logic [703:0] gsum;
    logic [895:0] g2sum;
    logic [895:0] fg;
    logic [3:0]   best_idx;
    logic [95:0]  best_cost;
    logic         out_valid;
    logic         busy;
    logic         overrun;

    int vectors;
    int miscompares;

    logic [43:0] lane_gs [16];
    logic [55:0] lane_g2 [16];
    logic [55:0] lane_fg [16];

    // Results of the last run_scan call.
    int          r_lat;
    int          r_pulses;
    logic [3:0]  r_idx;
    logic [95:0] r_cost;
    logic        r_busy_load;
    logic        r_busy_done;
    logic        r_hold_ok;

    ncc_select dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .fsum      (fsum),
        .f2sum     (f2sum),
        .gsum      (gsum),
        .g2sum     (g2sum),
        .fg        (fg),
        .best_idx  (best_idx),
        .best_cost (best_cost),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic pack();
        for (int i = 0; i < 16; i++) begin
            gsum[44*i +: 44]  = lane_gs[i];
            g2sum[56*i +: 56] = lane_g2[i];
            fg[56*i +: 56]    = lane_fg[i];
        end
    endtask

    task automatic fill(input logic [43:0] gs, input logic [55:0] g2, input logic [55:0] f);
        for (int i = 0; i < 16; i++) begin
            lane_gs[i] = gs;
            lane_g2[i] = g2;
            lane_fg[i] = f;
        end
    endtask

    // Drive valid low then high; the trigger is sampled on the next posedge.
    task automatic start_trigger();
        @(negedge clk);
        pack();
        valid = 1'b0;
        @(negedge clk);
        valid = 1'b1;
    endtask

    // Watch 45 cycles after the trigger edge. Optionally pulse valid mid-scan
    // and change the inputs to something else at the same time.
    task automatic run_scan(input bit glitch);
        r_lat       = -1;
        r_pulses    = 0;
        r_idx       = '0;
        r_cost      = '0;
        r_busy_load = 1'b0;
        r_busy_done = 1'b1;
        r_hold_ok   = 1'b1;
        for (int cnt = 1; cnt <= 45; cnt++) begin
            @(negedge clk);
            if (cnt == 1)  r_busy_load = busy;
            if (cnt == 18) r_busy_done = busy;
            if (glitch && cnt == 5) valid = 1'b0;
            if (glitch && cnt == 6) begin
                fill(44'd0, 56'd0, 56'd0);
                pack();
                valid = 1'b1;
            end
            if (out_valid) begin
                r_pulses++;
                if (r_lat < 0) begin
                    r_lat  = cnt;
                    r_idx  = best_idx;
                    r_cost = best_cost;
                end
            end else if (r_lat > 0) begin
                if (best_idx !== r_idx || best_cost !== r_cost) r_hold_ok = 1'b0;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int pulses;
        int busies;
        rst_n = 1'b0;
        valid = 1'b1;
        fill(44'd1, 56'd1, 56'd0);
        fsum  = 11'd0;
        f2sum = 14'd0;
        pack();
        repeat (3) @(negedge clk);
        vectors++;
        if ({best_idx, best_cost, out_valid, busy, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got idx=%0d cost=%0d ov=%0b busy=%0b orun=%0b want all 0",
                     best_idx, best_cost, out_valid, busy, overrun);
        end
        rst_n  = 1'b1;
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
            if (busy) busies++;
        end
        vectors++;
        if (pulses !== 0 || busies !== 0) begin
            miscompares++;
            $display("FAIL reset_high_valid_no_trigger got pulses=%0d busy_cycles=%0d want 0 0", pulses, busies);
        end
        vectors++;
        if ({best_idx, best_cost, overrun} !== '0) begin
            miscompares++;
            $display("FAIL reset_hold_outputs got idx=%0d cost=%0d orun=%0b want 0 0 0", best_idx, best_cost, overrun);
        end
    endtask

`ifndef NCC_ZSSD_EN
    task automatic test_basic();
        f2sum = 14'd100;
        fill(44'd0, 56'd300, 56'd10);
        lane_g2[5] = 56'd100;
        lane_fg[5] = 56'd100;
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_lat !== 19) begin
            miscompares++;
            $display("FAIL basic_latency got %0d want 19", r_lat);
        end
        vectors++;
        if (r_idx !== 4'd5 || r_cost !== 96'd0) begin
            miscompares++;
            $display("FAIL basic_result got idx=%0d cost=%0d want idx=5 cost=0", r_idx, r_cost);
        end
        vectors++;
        if (r_busy_load !== 1'b1 || r_busy_done !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy got load=%0b done=%0b want 1 0", r_busy_load, r_busy_done);
        end
        vectors++;
        if (r_pulses !== 1 || r_hold_ok !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_pulse_hold got pulses=%0d hold=%0b orun=%0b want 1 1 0", r_pulses, r_hold_ok, overrun);
        end
    endtask

    task automatic test_ties();
        f2sum = 14'd10;
        fill(44'd0, 56'd50, 56'd20);
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_lat !== 19 || r_idx !== 4'd0 || r_cost !== 96'd20) begin
            miscompares++;
            $display("FAIL ties_all_equal got lat=%0d idx=%0d cost=%0d want 19 0 20", r_lat, r_idx, r_cost);
        end
        // Two lanes share the minimum: lowest index wins.
        f2sum = 14'd0;
        fill(44'd0, 56'd1000, 56'd0);
        lane_g2[4]  = 56'd7;
        lane_g2[10] = 56'd7;
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_idx !== 4'd4 || r_cost !== 96'd7) begin
            miscompares++;
            $display("FAIL ties_mid got idx=%0d cost=%0d want 4 7", r_idx, r_cost);
        end
    endtask

    task automatic test_last_lane();
        // cost_i = 1000 + (2000 - 10*i) = 3000 - 10*i; lane 15 -> 2850.
        f2sum = 14'd1000;
        for (int i = 0; i < 16; i++) begin
            lane_gs[i] = 44'd0;
            lane_g2[i] = 56'(2000 - 10 * i);
            lane_fg[i] = 56'd0;
        end
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_idx !== 4'd15 || r_cost !== 96'd2850) begin
            miscompares++;
            $display("FAIL last_lane got idx=%0d cost=%0d want 15 2850", r_idx, r_cost);
        end
        // Wide operands: lane 9 = 16383 + 2^55 - 2*2^54 = 16383, others larger.
        f2sum = 14'd16383;
        fill(44'd0, 56'hFF_FFFF_FFFF_FFFF, 56'd0);
        lane_g2[9] = 56'h80_0000_0000_0000;
        lane_fg[9] = 56'h40_0000_0000_0000;
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_idx !== 4'd9 || r_cost !== 96'd16383) begin
            miscompares++;
            $display("FAIL wide_lane got idx=%0d cost=%0d want 9 16383", r_idx, r_cost);
        end
    endtask

    task automatic test_clamp();
        f2sum = 14'd0;
        fill(44'd0, 56'd500, 56'd0);
        lane_g2[3] = 56'd0;
        lane_fg[3] = 56'd1000;
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_idx !== 4'd3 || r_cost !== 96'd0) begin
            miscompares++;
            $display("FAIL clamp got idx=%0d cost=%0d want 3 0", r_idx, r_cost);
        end
    endtask

    task automatic test_overrun();
        f2sum = 14'd100;
        fill(44'd0, 56'd300, 56'd10);
        lane_g2[5] = 56'd100;
        lane_fg[5] = 56'd100;
        start_trigger();
        run_scan(1'b1);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_flag got %0b want 1", overrun);
        end
        vectors++;
        if (r_lat !== 19 || r_idx !== 4'd5 || r_cost !== 96'd0) begin
            miscompares++;
            $display("FAIL overrun_result got lat=%0d idx=%0d cost=%0d want 19 5 0", r_lat, r_idx, r_cost);
        end
        vectors++;
        if (r_pulses !== 1) begin
            miscompares++;
            $display("FAIL overrun_pulses got %0d want 1", r_pulses);
        end
    endtask
`else
    task automatic test_zssd();
        // lane 7: 256*(256+256-512) - (256-256)^2 = 0
        // others: 256*(256+1000-0) - (256-0)^2 = 321536 - 65536 = 256000
        fsum  = 11'd256;
        f2sum = 14'd256;
        fill(44'd0, 56'd1000, 56'd0);
        lane_gs[7] = 44'd256;
        lane_g2[7] = 56'd256;
        lane_fg[7] = 56'd256;
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_lat !== 19 || r_idx !== 4'd7 || r_cost !== 96'd0) begin
            miscompares++;
            $display("FAIL zssd_lane7 got lat=%0d idx=%0d cost=%0d want 19 7 0", r_lat, r_idx, r_cost);
        end
        // all lanes: 256*(10+50-40) - (100-90)^2 = 5120 - 100 = 5020, tie -> 0
        fsum  = 11'd100;
        f2sum = 14'd10;
        fill(44'd90, 56'd50, 56'd20);
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_idx !== 4'd0 || r_cost !== 96'd5020) begin
            miscompares++;
            $display("FAIL zssd_ties got idx=%0d cost=%0d want 0 5020", r_idx, r_cost);
        end
        // lane 2: 256*0 - (2047-0)^2 < 0 -> clamp 0; others gsum=2047 -> 256*500
        fsum  = 11'd2047;
        f2sum = 14'd0;
        fill(44'd2047, 56'd500, 56'd0);
        lane_gs[2] = 44'd0;
        lane_g2[2] = 56'd0;
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_idx !== 4'd2 || r_cost !== 96'd0) begin
            miscompares++;
            $display("FAIL zssd_clamp got idx=%0d cost=%0d want 2 0", r_idx, r_cost);
        end
        vectors++;
        if (r_busy_load !== 1'b1 || r_busy_done !== 1'b0 || r_pulses !== 1 || r_hold_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL zssd_ctrl got busy=%0b/%0b pulses=%0d hold=%0b want 1/0 1 1",
                     r_busy_load, r_busy_done, r_pulses, r_hold_ok);
        end
    endtask
`endif

    task automatic test_reset_mid_scan();
        int pulses;
        fsum  = 11'd0;
        f2sum = 14'd0;
        fill(44'd0, 56'd500, 56'd0);
        lane_g2[11] = 56'd3;
        start_trigger();
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({best_idx, best_cost, out_valid, busy, overrun} !== '0) begin
            miscompares++;
            $display("FAIL midscan_reset_outputs got idx=%0d cost=%0d ov=%0b busy=%0b orun=%0b want all 0",
                     best_idx, best_cost, out_valid, busy, overrun);
        end
        valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL midscan_no_pulse got %0d want 0", pulses);
        end
        // Block recovers and scans normally afterwards.
        start_trigger();
        run_scan(1'b0);
        vectors++;
        if (r_lat !== 19 || r_idx !== 4'd11) begin
            miscompares++;
            $display("FAIL post_reset_scan got lat=%0d idx=%0d want 19 11", r_lat, r_idx);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        valid       = 1'b0;
        fsum        = '0;
        f2sum       = '0;
        gsum        = '0;
        g2sum       = '0;
        fg          = '0;
        test_reset();
`ifndef NCC_ZSSD_EN
        test_basic();
        test_ties();
        test_last_lane();
        test_clamp();
        test_overrun();
`else
        test_zssd();
`endif
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
